// File: rtl/tlb_op_ctrl_pkg.sv
// tlb_op_ctrl_pkg: shared types and constants for the TLB maintenance sequencer.
//   tlb_op_t         - backend operation encoding (SRCH/RD/WR/FILL/INV)
//   tlb_ctrl_state_t - sequencer FSM states
//   tlb_entry_t      - TLB entry image exchanged with the mmu
//   LFSR_SEED/TAPS   - fill-victim LFSR constants (used when TLB_FILL_LFSR_EN is defined)
package tlb_op_ctrl_pkg;

  localparam int TLBNUM   = 16;
  localparam int TLBIDLEN = 4;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SRCH,
    ST_RD0,
    ST_RD1,
    ST_WR,
    ST_INV,
    ST_RESP
  } tlb_ctrl_state_t;

  // Fibonacci taps 8,6,5,4 (1-based) -> bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef struct packed {
    logic        e;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
    logic [19:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_op_ctrl_fill_idx.sv
// tlb_fill_idx_gen: TLBFILL victim index generator.
//   Macro TLB_FILL_LFSR_EN selects an 8-bit free-running LFSR (low TLBIDLEN bits
//   are the index); otherwise a round-robin counter that advances per completed FILL.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   fill_done in   one-cycle pulse when a FILL write is issued
//   index     out  victim index for the next FILL
module tlb_fill_idx_gen
  import tlb_op_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                fill_done,
  output logic [TLBIDLEN-1:0] index
);

`ifdef TLB_FILL_LFSR_EN
  logic [7:0] lfsr_q;
  logic       unused_fill_done;

  assign unused_fill_done = fill_done;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign index = lfsr_q[TLBIDLEN-1:0];
`else
  logic [TLBIDLEN-1:0] cnt_q;

  // TLBNUM is a power of two, so natural overflow gives the wrap to 0.
  always_ff @(posedge clk) begin
    if (reset)          cnt_q <= '0;
    else if (fill_done) cnt_q <= cnt_q + 1'b1;
  end

  assign index = cnt_q;
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: serialises TLB maintenance ops (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB)
// between the backend and the mmu, arbitrates the mmu s1 lookup port against LSU
// lookups, and returns a one-cycle response.
// Optional feature macro: TLB_FILL_LFSR_EN (LFSR fill victim instead of counter).
// Ports:
//   req_*            backend request; accepted when req_valid && req_ready (IDLE only)
//   resp_*           one-cycle completion pulse with search/read results
//   d_valid_in/out   LSU lookup request in / gated towards mmu; d_ok_in = mmu d_ok
//   tlb_we/w_*       mmu write port;  tlb_r_index/tlb_r_entry  mmu read port
//   is_tlbsrch, tlbsrch_*  mmu s1 search; invtlb_*  mmu invalidate
//   busy             high whenever an op is in progress
// req_op is a raw 3-bit field so reserved encodings can be recognised and retired.
//
// state | meaning
// IDLE  | ready for a request
// ARB   | SRCH waiting for the s1 port to go free
// SRCH  | search issued on s1, waiting for tlbsrch_ok
// RD0   | read index presented to mmu
// RD1   | read data captured at end of cycle
// WR    | one-cycle write (WR or FILL)
// INV   | one-cycle invalidate
// RESP  | resp_valid pulse
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [TLBIDLEN-1:0] req_index,
  input  tlb_entry_t          req_entry,
  input  logic [18:0]         req_vppn,
  input  logic [4:0]          req_inv_op,
  input  logic [9:0]          req_inv_asid,
  input  logic [31:0]         req_inv_va,
  output logic                resp_valid,
  output logic                resp_found,
  output logic [TLBIDLEN-1:0] resp_index,
  output tlb_entry_t          resp_entry,
  input  logic                d_valid_in,
  input  logic                d_ok_in,
  output logic                d_valid_out,
  output logic                tlb_we,
  output logic [TLBIDLEN-1:0] tlb_w_index,
  output tlb_entry_t          tlb_w_entry,
  output logic [TLBIDLEN-1:0] tlb_r_index,
  input  tlb_entry_t          tlb_r_entry,
  output logic                is_tlbsrch,
  output logic                tlbsrch_valid,
  output logic [18:0]         tlbsrch_vppn,
  input  logic                tlbsrch_ok,
  input  logic                tlbsrch_found,
  input  logic [TLBIDLEN-1:0] tlbsrch_index,
  output logic                invtlb_valid,
  output logic [4:0]          invtlb_op,
  output logic [9:0]          invtlb_asid,
  output logic [31:0]         invtlb_va,
  output logic                busy
);

  tlb_ctrl_state_t     state_q, state_d;
  logic [2:0]          op_q;
  logic [TLBIDLEN-1:0] index_q;
  tlb_entry_t          entry_q;
  logic [18:0]         vppn_q;
  logic [4:0]          inv_op_q;
  logic [9:0]          inv_asid_q;
  logic [31:0]         inv_va_q;
  logic                found_q;
  logic [TLBIDLEN-1:0] resp_index_q;
  tlb_entry_t          rd_entry_q;

  logic                accept;
  logic                s1_free;
  logic                gate_lsu;
  logic                fill_done;
  logic [TLBIDLEN-1:0] fill_idx;
  logic [TLBIDLEN-1:0] wr_index;

  tlb_fill_idx_gen u_fill_idx (
    .clk       (clk),
    .reset     (reset),
    .fill_done (fill_done),
    .index     (fill_idx)
  );

  assign accept   = req_valid && (state_q == ST_IDLE);
  assign s1_free  = !d_valid_in || d_ok_in;
  // FILL resolves its victim at accept so the index is stable for the write.
  assign wr_index = (req_op == OP_FILL) ? fill_idx : req_index;

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    tlb_we        = 1'b0;
    invtlb_valid  = 1'b0;
    is_tlbsrch    = 1'b0;
    tlbsrch_valid = 1'b0;
    gate_lsu      = 1'b0;
    fill_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_SRCH:         state_d = ST_ARB;
            OP_RD:           state_d = ST_RD0;
            OP_WR, OP_FILL:  state_d = ST_WR;
            OP_INV:          state_d = ST_INV;
            default:         state_d = ST_RESP;
          endcase
        end
      end
      ST_ARB: begin
        // Grant cycle already blocks the LSU so a newly arriving lookup cannot collide.
        if (s1_free) begin
          gate_lsu = 1'b1;
          state_d  = ST_SRCH;
        end
      end
      ST_SRCH: begin
        gate_lsu      = 1'b1;
        is_tlbsrch    = 1'b1;
        tlbsrch_valid = 1'b1;
        if (tlbsrch_ok) state_d = ST_RESP;
      end
      ST_RD0: state_d = ST_RD1;
      ST_RD1: state_d = ST_RESP;
      ST_WR: begin
        tlb_we    = 1'b1;
        fill_done = (op_q == OP_FILL);
        state_d   = ST_RESP;
      end
      ST_INV: begin
        invtlb_valid = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      index_q      <= '0;
      entry_q      <= '0;
      vppn_q       <= '0;
      inv_op_q     <= '0;
      inv_asid_q   <= '0;
      inv_va_q     <= '0;
      found_q      <= 1'b0;
      resp_index_q <= '0;
      rd_entry_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q         <= req_op;
        index_q      <= wr_index;
        entry_q      <= req_entry;
        vppn_q       <= req_vppn;
        inv_op_q     <= req_inv_op;
        inv_asid_q   <= req_inv_asid;
        inv_va_q     <= req_inv_va;
        found_q      <= 1'b0;
        resp_index_q <= (req_op == OP_WR || req_op == OP_FILL) ? wr_index : '0;
        rd_entry_q   <= '0;
      end
      if (state_q == ST_SRCH && tlbsrch_ok) begin
        found_q      <= tlbsrch_found;
        resp_index_q <= tlbsrch_index;
      end
      if (state_q == ST_RD1) rd_entry_q <= tlb_r_entry;
    end
  end

  assign d_valid_out  = d_valid_in && !gate_lsu;
  assign tlb_w_index  = index_q;
  assign tlb_w_entry  = entry_q;
  assign tlb_r_index  = index_q;
  assign tlbsrch_vppn = vppn_q;
  assign invtlb_op    = inv_op_q;
  assign invtlb_asid  = inv_asid_q;
  assign invtlb_va    = inv_va_q;
  assign resp_found   = found_q;
  assign resp_index   = resp_index_q;
  assign resp_entry   = rd_entry_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed bench for tlb_op_ctrl. Each op task schedules, per
// absolute cycle, what the outputs must show (derived from the op latencies);
// a negedge process compares every cycle. A small mmu model holds TLB contents.
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, req_valid, req_ready;
  logic [2:0]          req_op;
  logic [TLBIDLEN-1:0] req_index;
  tlb_entry_t          req_entry;
  logic [18:0]         req_vppn;
  logic [4:0]          req_inv_op;
  logic [9:0]          req_inv_asid;
  logic [31:0]         req_inv_va;
  logic                resp_valid, resp_found;
  logic [TLBIDLEN-1:0] resp_index;
  tlb_entry_t          resp_entry;
  logic                d_valid_in, d_ok_in, d_valid_out;
  logic                tlb_we;
  logic [TLBIDLEN-1:0] tlb_w_index, tlb_r_index;
  tlb_entry_t          tlb_w_entry, tlb_r_entry;
  logic                is_tlbsrch, tlbsrch_valid, tlbsrch_ok, tlbsrch_found;
  logic [18:0]         tlbsrch_vppn;
  logic [TLBIDLEN-1:0] tlbsrch_index;
  logic                invtlb_valid;
  logic [4:0]          invtlb_op;
  logic [9:0]          invtlb_asid;
  logic [31:0]         invtlb_va;
  logic                busy;

  tlb_op_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_index(req_index), .req_entry(req_entry), .req_vppn(req_vppn),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_va(req_inv_va),
    .resp_valid(resp_valid), .resp_found(resp_found), .resp_index(resp_index),
    .resp_entry(resp_entry), .d_valid_in(d_valid_in), .d_ok_in(d_ok_in),
    .d_valid_out(d_valid_out), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_w_entry(tlb_w_entry), .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .is_tlbsrch(is_tlbsrch), .tlbsrch_valid(tlbsrch_valid), .tlbsrch_vppn(tlbsrch_vppn),
    .tlbsrch_ok(tlbsrch_ok), .tlbsrch_found(tlbsrch_found), .tlbsrch_index(tlbsrch_index),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_va(invtlb_va), .busy(busy)
  );

  // mmu model: storage written through the DUT write port, read combinationally.
  tlb_entry_t mmu_mem [TLBNUM];
  always @(posedge clk) if (tlb_we) mmu_mem[tlb_w_index] <= tlb_w_entry;
  assign tlb_r_entry = mmu_mem[tlb_r_index];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference fill-victim LFSR (only consulted in the LFSR build).
  logic [7:0] lfsr_m;
  always @(posedge clk)
    if (reset) lfsr_m <= 8'h01;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

  typedef struct packed {
    logic                found;
    logic                chk_idx;
    logic [TLBIDLEN-1:0] idx;
    logic                chk_ent;
    tlb_entry_t          ent;
  } resp_exp_t;

  bit                  m_busy [int];
  bit                  m_gate [int];
  logic [TLBIDLEN-1:0] m_we_idx [int];
  tlb_entry_t          m_we_ent [int];
  logic [46:0]         m_inv [int];
  logic [18:0]         m_srch [int];
  logic [TLBIDLEN-1:0] m_rd [int];
  resp_exp_t           m_resp [int];
  tlb_entry_t          tlb_m [TLBNUM];
  int                  fill_m;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;
  int k_cmp;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
  endfunction

  function automatic resp_exp_t mk_resp(input logic f, input logic ci, input logic [3:0] ix,
                                        input logic ce, input tlb_entry_t en);
    resp_exp_t r;
    r.found = f; r.chk_idx = ci; r.idx = ix; r.chk_ent = ce; r.ent = en;
    return r;
  endfunction

  function automatic tlb_entry_t mk_ent(input logic [18:0] vppn, input logic [19:0] ppn);
    tlb_entry_t e;
    e = '0; e.e = 1'b1; e.vppn = vppn; e.ppn = ppn; e.asid = vppn[9:0]; e.ps = 6'd12;
    return e;
  endfunction

  function automatic logic [3:0] fill_exp();
`ifdef TLB_FILL_LFSR_EN
    return lfsr_m[3:0];
`else
    return 4'(fill_m);
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      k_cmp = cyc;
      chk("req_ready", req_ready, !m_busy.exists(k_cmp));
      chk("busy", busy, m_busy.exists(k_cmp));
      chk("d_valid_out", d_valid_out, d_valid_in && !m_gate.exists(k_cmp));
      chk("tlb_we", tlb_we, m_we_idx.exists(k_cmp));
      if (m_we_idx.exists(k_cmp)) begin
        chk("tlb_w_index", tlb_w_index, m_we_idx[k_cmp]);
        chk("tlb_w_entry", tlb_w_entry, m_we_ent[k_cmp]);
      end
      chk("invtlb_valid", invtlb_valid, m_inv.exists(k_cmp));
      if (m_inv.exists(k_cmp))
        chk("invtlb_fields", {invtlb_op, invtlb_asid, invtlb_va}, m_inv[k_cmp]);
      chk("tlbsrch_valid", tlbsrch_valid, m_srch.exists(k_cmp));
      chk("is_tlbsrch", is_tlbsrch, m_srch.exists(k_cmp));
      if (m_srch.exists(k_cmp)) chk("tlbsrch_vppn", tlbsrch_vppn, m_srch[k_cmp]);
      if (m_rd.exists(k_cmp)) chk("tlb_r_index", tlb_r_index, m_rd[k_cmp]);
      chk("resp_valid", resp_valid, m_resp.exists(k_cmp));
      if (m_resp.exists(k_cmp)) begin
        chk("resp_found", resp_found, m_resp[k_cmp].found);
        if (m_resp[k_cmp].chk_idx) chk("resp_index", resp_index, m_resp[k_cmp].idx);
        if (m_resp[k_cmp].chk_ent) chk("resp_entry", resp_entry, m_resp[k_cmp].ent);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic [2:0] op, output int t);
    req_valid = 1'b1; req_op = op; t = cyc;
    next_cyc();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input bit fill, input logic [3:0] idx, input tlb_entry_t ent,
                          input bit hold_inv, output logic [3:0] obs_idx);
    int t; logic [3:0] wi;
    wi = fill ? fill_exp() : idx;
    req_index = idx; req_entry = ent;
    start_op(fill ? 3'(OP_FILL) : 3'(OP_WR), t);
    m_busy[t+1] = 1; m_busy[t+2] = 1;
    m_we_idx[t+1] = wi; m_we_ent[t+1] = ent;
    m_resp[t+2] = mk_resp(1'b0, 1'b1, wi, 1'b0, '0);
    tlb_m[wi] = ent;
    if (fill) fill_m = (fill_m + 1) % TLBNUM;
    #3 obs_idx = tlb_w_index;
    next_cyc();
    if (hold_inv) begin req_valid = 1'b1; req_op = 3'(OP_INV); end
    next_cyc();
  endtask

  task automatic do_rd(input logic [3:0] idx, output tlb_entry_t obs);
    int t;
    req_index = idx;
    start_op(3'(OP_RD), t);
    m_busy[t+1] = 1; m_busy[t+2] = 1; m_busy[t+3] = 1;
    m_rd[t+1] = idx; m_rd[t+2] = idx;
    m_resp[t+3] = mk_resp(1'b0, 1'b0, '0, 1'b1, tlb_m[idx]);
    next_cyc(); next_cyc();
    #3 obs = resp_entry;
    next_cyc();
  endtask

  task automatic do_inv(input logic [4:0] op, input logic [9:0] asid, input logic [31:0] va,
                        output logic [46:0] obs);
    int t;
    req_inv_op = op; req_inv_asid = asid; req_inv_va = va;
    start_op(3'(OP_INV), t);
    m_busy[t+1] = 1; m_busy[t+2] = 1;
    m_inv[t+1] = {op, asid, va};
    m_resp[t+2] = mk_resp(1'b0, 1'b0, '0, 1'b0, '0);
    #3 obs = {invtlb_op, invtlb_asid, invtlb_va};
    next_cyc(); next_cyc();
  endtask

  // Reserved opcode: retires in one cycle with found=0 and no mmu action.
  task automatic do_bad(output logic obs);
    int t;
    start_op(3'd7, t);
    m_busy[t+1] = 1;
    m_resp[t+1] = mk_resp(1'b0, 1'b0, '0, 1'b0, '0);
    #3 obs = resp_valid;
    next_cyc();
  endtask

  // nwait: cycles the LSU holds s1 in ARB; okd: extra SRCH cycles before tlbsrch_ok.
  task automatic do_srch(input logic [18:0] vppn, input int nwait, input int okd,
                         input logic found, input logic [3:0] idx, input bit abort,
                         output logic [7:0] obs);
    int t, c;
    req_vppn = vppn; d_valid_in = (nwait > 0); d_ok_in = 1'b0;
    start_op(3'(OP_SRCH), t);
    c = t + 1;
    for (int i = 0; i < nwait; i++) begin
      m_busy[c] = 1; next_cyc(); c++;
    end
    m_busy[c] = 1; m_gate[c] = 1; d_ok_in = (nwait > 0);
    next_cyc(); c++;
    d_ok_in = 1'b0; d_valid_in = 1'b1;
    m_busy[c] = 1; m_gate[c] = 1; m_srch[c] = vppn;
    if (abort) begin
      reset = 1'b1;
      next_cyc(); c++;
      reset = 1'b0; d_valid_in = 1'b0; fill_m = 0;
      #3 obs = {5'd0, tlbsrch_valid, req_ready, resp_valid};
      next_cyc();
    end else begin
      for (int i = 0; i < okd; i++) begin
        next_cyc(); c++;
        m_busy[c] = 1; m_gate[c] = 1; m_srch[c] = vppn;
      end
      tlbsrch_ok = 1'b1; tlbsrch_found = found; tlbsrch_index = idx;
      next_cyc(); c++;
      tlbsrch_ok = 1'b0; tlbsrch_found = 1'b0; tlbsrch_index = '0; d_valid_in = 1'b0;
      m_busy[c] = 1;
      m_resp[c] = mk_resp(found, 1'b1, idx, 1'b0, '0);
      #3 obs = {3'd0, resp_found, resp_index};
      next_cyc();
    end
  endtask

  logic [3:0]  o_idx;
  tlb_entry_t  o_ent;
  logic [46:0] o_inv;
  logic [7:0]  o_srch;
  logic        o_bit;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_index = '0; req_entry = '0;
    req_vppn = '0; req_inv_op = '0; req_inv_asid = '0; req_inv_va = '0;
    d_valid_in = 1'b1; d_ok_in = 1'b0;
    tlbsrch_ok = 1'b0; tlbsrch_found = 1'b0; tlbsrch_index = '0;
    fill_m = 0;
    for (int i = 0; i < TLBNUM; i++) begin mmu_mem[i] = '0; tlb_m[i] = '0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    #3;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_tlb_we", tlb_we, 1'b0);
    chk("rst_w_index", tlb_w_index, 4'd0);
    chk("rst_invtlb_va", invtlb_va, 32'd0);
    chk("rst_d_valid_out", d_valid_out, 1'b1);
    d_valid_in = 1'b0;
`ifdef TLB_FILL_LFSR_EN
    do_write(1'b1, 4'd0, mk_ent(19'h00abc, 20'h00111), 1'b0, o_idx);
    chk("lfsr_first_fill", o_idx, 4'd1);
`endif

    do_write(1'b0, 4'd5, mk_ent(19'h01234, 20'h05678), 1'b0, o_idx);
    chk("wr5_w_index", o_idx, 4'd5);
    do_rd(4'd5, o_ent);
    chk("rd5_vppn", o_ent.vppn, 19'h01234);

    req_inv_op = 5'd5; req_inv_asid = 10'h3; req_inv_va = 32'h8000_0000;
    do_write(1'b0, 4'd10, mk_ent(19'h7ffff, 20'hfffff), 1'b1, o_idx);
    do_inv(5'd5, 10'h3, 32'h8000_0000, o_inv);
    chk("inv_fields", o_inv, {5'd5, 10'h3, 32'h8000_0000});

    do_srch(19'h0abcd, 3, 0, 1'b1, 4'd9, 1'b0, o_srch);
    chk("srch_hit_found_idx", o_srch, {3'd0, 1'b1, 4'd9});
    do_srch(19'h00077, 0, 2, 1'b0, 4'd3, 1'b0, o_srch);
    chk("srch_miss_found", o_srch[4], 1'b0);

    do_bad(o_bit);
    chk("bad_op_resp", o_bit, 1'b1);

    do_srch(19'h12345, 0, 0, 1'b1, 4'd1, 1'b1, o_srch);
    chk("abort_srch_valid_ready_resp", o_srch[2:0], 3'b010);

    for (int i = 0; i < 17; i++) begin
      do_write(1'b1, 4'd0, mk_ent(19'(i * 3 + 1), 20'(i + 100)), 1'b0, o_idx);
`ifndef TLB_FILL_LFSR_EN
      if (i == 0)  chk("fill_cnt_0", o_idx, 4'd0);
      if (i == 1)  chk("fill_cnt_1", o_idx, 4'd1);
      if (i == 2)  chk("fill_cnt_2", o_idx, 4'd2);
      if (i == 15) chk("fill_cnt_15", o_idx, 4'd15);
      if (i == 16) chk("fill_cnt_wrap", o_idx, 4'd0);
`endif
    end
    do_rd(4'd15, o_ent);
    do_rd(4'd0, o_ent);

    do_write(1'b0, 4'd7, mk_ent(19'h2468a, 20'h13579), 1'b0, o_idx);
    do_rd(4'd7, o_ent);
    chk("rd7_vppn", o_ent.vppn, 19'h2468a);
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
